// File: rtl/isram_arb.sv
// rtl/isram_arb.sv - single-port ISRAM arbiter between instruction fetch and a data requester
// Optional starvation bypass with fetch replay: define ISRAM_ARB_STARVE_EN.
module isram_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        f_cs,
  input  logic [28:0] f_adr,
  input  logic        f_kill,
  output logic [63:0] f_rdata,
  output logic        f_rvalid,
  output logic        fet_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [28:0] d_adr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wbe,
  output logic        d_gnt,
  output logic [63:0] d_rdata,
  output logic        d_rvalid,
  output logic        sram_cs,
  output logic        sram_we,
  output logic [28:0] sram_adr,
  output logic [63:0] sram_wdata,
  output logic [7:0]  sram_wbe,
  input  logic [63:0] sram_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_FET, OWN_DAT} owner_t;

  owner_t      owner;
  logic        own_rd;
  logic        d_win;
  logic        f_win;
  logic        rpl_win;
  logic [28:0] fet_adr;

`ifdef ISRAM_ARB_STARVE_EN
  typedef enum logic {S_FET, S_RPL} state_t;

  state_t      state;
  logic [2:0]  starve_cnt;
  logic [28:0] rpl_adr;
  logic        starved;

  assign starved = (starve_cnt == 3'(STARVE_MAX));

  // A pending replay owns the port outright; f_kill drops it without an access.
  assign rpl_win   = cpurst_n && (state == S_RPL) && !f_kill;
  assign d_win     = cpurst_n && (state == S_FET) && d_req && (!f_cs || starved);
  assign f_win     = cpurst_n && (state == S_FET) && f_cs && !d_win;
  assign fet_stall = cpurst_n && ((state == S_RPL) || (d_win && f_cs));
  assign fet_adr   = (state == S_RPL) ? rpl_adr : f_adr;

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state      <= S_FET;
      starve_cnt <= '0;
      rpl_adr    <= '0;
    end else begin
      case (state)
        S_FET: begin
          if (d_win && f_cs) begin
            state   <= S_RPL;
            rpl_adr <= f_adr;
          end
        end
        S_RPL: state <= S_FET;
      endcase
      if (!d_req || d_win) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  // Strict fetch priority: the starvation limit has no effect in this build.
  logic [2:0] unused_starve_max;
  assign unused_starve_max = 3'(STARVE_MAX);

  assign rpl_win   = 1'b0;
  assign d_win     = cpurst_n && d_req && !f_cs;
  assign f_win     = cpurst_n && f_cs;
  assign fet_stall = 1'b0;
  assign fet_adr   = f_adr;
`endif

  assign d_gnt      = d_win;
  assign sram_cs    = d_win | f_win | rpl_win;
  assign sram_we    = d_win & d_we;
  assign sram_adr   = d_win ? d_adr : (sram_cs ? fet_adr : '0);
  assign sram_wdata = sram_we ? d_wdata : '0;
  assign sram_wbe   = sram_we ? d_wbe : '0;

  // Owner of the access issued last cycle decides where sram_rdata goes.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      owner  <= OWN_NONE;
      own_rd <= 1'b0;
    end else begin
      own_rd <= d_win ? !d_we : 1'b1;
      if (d_win) begin
        owner <= OWN_DAT;
      end else if (f_win || rpl_win) begin
        owner <= OWN_FET;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  assign f_rvalid = (owner == OWN_FET) && !f_kill;
  assign d_rvalid = (owner == OWN_DAT) && own_rd;
  assign f_rdata  = sram_rdata;
  assign d_rdata  = sram_rdata;

endmodule

// File: tb/tb_isram_arb.sv
// tb/tb_isram_arb.sv - self-checking bench for isram_arb (either ISRAM_ARB_STARVE_EN build)
module tb_isram_arb;
  localparam int STARVE_MAX = 4;
  localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  logic        clk = 1'b0;
  logic        cpurst_n = 1'b0;
  logic        f_cs = 1'b0, f_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [28:0] f_adr = '0, d_adr = '0;
  logic [63:0] d_wdata = '0;
  logic [7:0]  d_wbe = '0;
  logic [63:0] f_rdata, d_rdata, sram_wdata, sram_rdata;
  logic        f_rvalid, fet_stall, d_gnt, d_rvalid, sram_cs, sram_we;
  logic [28:0] sram_adr;
  logic [7:0]  sram_wbe;

  isram_arb dut (
    .clk(clk), .cpurst_n(cpurst_n), .f_cs(f_cs), .f_adr(f_adr), .f_kill(f_kill),
    .f_rdata(f_rdata), .f_rvalid(f_rvalid), .fet_stall(fet_stall),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_wbe(d_wbe),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr),
    .sram_wdata(sram_wdata), .sram_wbe(sram_wbe), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int a);
    return {32'hC0DE_0000 + 32'(a), 32'h1234_5678 ^ 32'(a << 4)};
  endfunction

  // SRAM macro: byte-enabled write, one-cycle registered read
  logic [63:0] sram_mem [1024];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_wbe[b]) sram_mem[sram_adr[9:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_adr[9:0]];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: kind 0 none, 1 fetch read, 2 data read, 3 data write
  logic [63:0] ref_mem [1024];
  bit          m_rpl;
  logic [28:0] m_rpl_adr;
  int          m_wait;
  int          m_last;
  logic [28:0] m_last_adr;
  bit          e_gnt, e_stall;

  task automatic model_reset();
    m_rpl = 0; m_rpl_adr = '0; m_wait = 0; m_last = 0; m_last_adr = '0;
    e_gnt = 0; e_stall = 0;
  endtask

  task automatic step(input bit fcs, input logic [28:0] fadr, input bit fkill, input bit dreq,
                      input bit dwe, input logic [28:0] dadr, input logic [63:0] dwd,
                      input logic [7:0] dbe);
    int kind;
    logic [28:0] adr;
    bit gnt, stall;
    @(negedge clk);
    f_cs = fcs; f_adr = fadr; f_kill = fkill; d_req = dreq; d_we = dwe;
    d_adr = dadr; d_wdata = dwd; d_wbe = dbe;
    #1;
    chk_b("f_rvalid", f_rvalid, m_last == 1 && !fkill);
    if (m_last == 1 && !fkill) chk_v("f_rdata", f_rdata, ref_mem[m_last_adr[9:0]]);
    chk_b("d_rvalid", d_rvalid, m_last == 2);
    if (m_last == 2) chk_v("d_rdata", d_rdata, ref_mem[m_last_adr[9:0]]);
    kind = 0; adr = '0; gnt = 0; stall = 0;
`ifdef ISRAM_ARB_STARVE_EN
    if (m_rpl) begin
      stall = 1;
      if (!fkill) begin kind = 1; adr = m_rpl_adr; end
    end else if (dreq && (!fcs || m_wait >= STARVE_MAX)) begin
      gnt = 1; stall = fcs;
    end else if (fcs) begin
      kind = 1; adr = fadr;
    end
`else
    if (dreq && !fcs) gnt = 1;
    else if (fcs) begin kind = 1; adr = fadr; end
`endif
    if (gnt) begin kind = dwe ? 3 : 2; adr = dadr; end
    chk_b("d_gnt", d_gnt, gnt);
    chk_b("fet_stall", fet_stall, stall);
    chk_b("sram_cs", sram_cs, kind != 0);
    chk_b("sram_we", sram_we, kind == 3);
    if (kind != 0) chk_v("sram_adr", 64'(sram_adr), 64'(adr));
    if (kind == 3) begin
      chk_v("sram_wdata", sram_wdata, dwd);
      chk_v("sram_wbe", 64'(sram_wbe), 64'(dbe));
      for (int b = 0; b < 8; b++)
        if (dbe[b]) ref_mem[adr[9:0]][8*b +: 8] = dwd[8*b +: 8];
    end
`ifdef ISRAM_ARB_STARVE_EN
    if (!m_rpl && gnt && fcs) begin m_rpl = 1; m_rpl_adr = fadr; end
    else m_rpl = 0;
    m_wait = (dreq && !gnt) ? ((m_wait < STARVE_MAX) ? m_wait + 1 : m_wait) : 0;
`endif
    m_last = kind; m_last_adr = adr;
    e_gnt = gnt; e_stall = stall;
  endtask

  task automatic idle(input bit fkill);
    step(0, '0, fkill, 0, 0, '0, '0, '0);
  endtask

  task automatic chk_ctrl_zero(input string tag);
    chk_b({tag, "_sram_cs"}, sram_cs, 1'b0);
    chk_b({tag, "_sram_we"}, sram_we, 1'b0);
    chk_b({tag, "_d_gnt"}, d_gnt, 1'b0);
    chk_b({tag, "_fet_stall"}, fet_stall, 1'b0);
    chk_b({tag, "_f_rvalid"}, f_rvalid, 1'b0);
    chk_b({tag, "_d_rvalid"}, d_rvalid, 1'b0);
  endtask

  typedef struct {
    bit fcs; logic [28:0] fadr; bit fkill; bit dreq; bit dwe; logic [28:0] dadr;
    logic [63:0] dwd; logic [7:0] dbe;
    bit cs; logic [28:0] sadr; bit gnt; bit frv; bit drv;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit fcs, input int fadr, input bit fkill, input bit dreq,
                              input bit dwe, input int dadr, input logic [63:0] dwd,
                              input logic [7:0] dbe, input bit cs, input int sadr,
                              input bit gnt, input bit frv, input bit drv);
    vec_t v;
    v.fcs = fcs; v.fadr = 29'(fadr); v.fkill = fkill; v.dreq = dreq; v.dwe = dwe;
    v.dadr = 29'(dadr); v.dwd = dwd; v.dbe = dbe;
    v.cs = cs; v.sadr = 29'(sadr); v.gnt = gnt; v.frv = frv; v.drv = drv;
    return v;
  endfunction

  logic [63:0] w;
  logic [28:0] pc;
  bit          rq, rwe, done;
  logic [28:0] radr;
  logic [63:0] rwd;
  logic [7:0]  rbe;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_reset();
    f_cs = 1; d_req = 1; f_adr = 29'h10; d_adr = 29'h20;
    repeat (2) @(negedge clk);
    #1;
    chk_ctrl_zero("reset");
    @(negedge clk);
    f_cs = 0; d_req = 0; cpurst_n = 1;

    tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, '0, '0, 1, 'h100, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h200, '0, '0, 1, 'h200, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h40, A5, 8'h0F, 1, 'h40, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h40, 0, 0, 0, 0, '0, '0, 1, 'h40, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 'h101, 0, 0, 0, 0, '0, '0, 1, 'h101, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h7, 0, 1, 0, 'h9, '0, '0, 1, 'h7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h9, '0, '0, 1, 'h9, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 'h3, 0, 0, 0, 0, '0, '0, 1, 'h3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h5, '0, '0, 1, 'h5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, '0, '0, 0, 0, 0, 0, 1));
    foreach (tbl[i]) begin
      step(tbl[i].fcs, tbl[i].fadr, tbl[i].fkill, tbl[i].dreq, tbl[i].dwe, tbl[i].dadr,
           tbl[i].dwd, tbl[i].dbe);
      chk_b("tbl_cs", sram_cs, tbl[i].cs);
      if (tbl[i].cs) chk_v("tbl_adr", 64'(sram_adr), 64'(tbl[i].sadr));
      chk_b("tbl_gnt", d_gnt, tbl[i].gnt);
      chk_b("tbl_stall", fet_stall, 1'b0);
      chk_b("tbl_frv", f_rvalid, tbl[i].frv);
      chk_b("tbl_drv", d_rvalid, tbl[i].drv);
      if (i == 7) begin
        w = init_word('h40);
        chk_v("wbe_merge", f_rdata, {w[63:32], 32'hA5A5_A5A5});
      end
    end

`ifdef ISRAM_ARB_STARVE_EN
    // continuous fetch versus a write: grant after STARVE_MAX waits, then replay
    pc = 29'h80; done = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, pc, 0, !done, 1, 29'h48, A5, 8'h0F);
      chk_b("starve_gnt", d_gnt, i == 4);
      chk_b("starve_stall", fet_stall, i == 4 || i == 5);
      if (i == 5) chk_v("replay_adr", 64'(sram_adr), 64'h84);
      if (i == 6) chk_b("replay_rvalid", f_rvalid, 1'b1);
      if (e_gnt) done = 1;
      if (!e_stall) pc = pc + 29'd1;
    end
    step(0, '0, 0, 1, 0, 29'h48, '0, '0);
    idle(0);
    w = init_word('h48);
    chk_v("starve_merge", d_rdata, {w[63:32], 32'hA5A5_A5A5});
    // bump followed by a flush while the replay is pending
    pc = 29'h90;
    for (int i = 0; i < 7; i++) begin
      step(1, pc, i == 5, i < 5, 0, 29'h12, '0, '0);
      if (i == 4) chk_b("kill_bump_gnt", d_gnt, 1'b1);
      if (i == 5) begin
        chk_b("kill_no_replay", sram_cs, 1'b0);
        chk_b("kill_stall", fet_stall, 1'b1);
      end
      if (i == 6) begin
        chk_b("kill_no_rvalid", f_rvalid, 1'b0);
        chk_b("kill_back_fet", fet_stall, 1'b0);
        chk_v("kill_fetch_adr", 64'(sram_adr), 64'(pc));
      end
      if (!e_stall) pc = pc + 29'd1;
    end
    idle(0);
    // bump with a data read, leaving S_RPL and a data response in flight
    for (int i = 0; i < 5; i++) step(1, 29'(8'hA0 + i), 0, 1, 0, 29'h30, '0, '0);
`else
    // strict priority: data waits as long as fetch keeps the port
    for (int i = 0; i < 10; i++) begin
      step(1, 29'(8'h20 + i), 0, 1, 0, 29'h11, '0, '0);
      chk_b("strict_no_gnt", d_gnt, 1'b0);
      chk_b("strict_no_stall", fet_stall, 1'b0);
    end
    step(0, '0, 0, 1, 0, 29'h11, '0, '0);
    chk_b("strict_gnt_on_drop", d_gnt, 1'b1);
    idle(0);
    step(0, '0, 0, 1, 0, 29'h30, '0, '0);
`endif
    chk_b("pre_rst_grant", d_gnt, 1'b1);
    @(negedge clk);
    f_cs = 1; f_adr = 29'h55; d_req = 1; d_we = 0; d_adr = 29'h31; f_kill = 0;
    #1;
    chk_b("pre_rst_d_rvalid", d_rvalid, 1'b1);
`ifdef ISRAM_ARB_STARVE_EN
    chk_b("pre_rst_stall", fet_stall, 1'b1);
`endif
    cpurst_n = 0;
    #1;
    chk_ctrl_zero("mid_reset");
    @(negedge clk);
    f_cs = 0; d_req = 0; cpurst_n = 1;
    model_reset();
    idle(0);
    chk_b("post_rst_no_rvalid", f_rvalid | d_rvalid, 1'b0);
    idle(0);

    rq = 0; rwe = 0; radr = '0; rwd = '0; rbe = '0; pc = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!rq && $urandom_range(0, 2) == 0) begin
        rq = 1; rwe = 1'($urandom_range(0, 1)); radr = 29'($urandom_range(0, 63));
        rwd = {$urandom, $urandom}; rbe = 8'($urandom);
      end
      if (!e_stall) pc = 29'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 15) == 0, rq, rwe, radr, rwd, rbe);
      if (e_gnt) rq = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
